// File: rtl/ahb_ext_ram_sub_if.sv
// AHB-Lite bus bundle between the SoC external-bus manager port and the
// external RAM subordinate.
interface ahb_ext_ram_sub_if #(
   parameter int AHBW    = 64,
   parameter int PA_BITS = 56
);
   logic                  HSELEXT;
   logic [PA_BITS-1:0]    HADDR;
   logic [1:0]            HTRANS;
   logic                  HWRITE;
   logic [2:0]            HSIZE;
   logic                  HREADY;
   logic [AHBW-1:0]       HWDATA;
   logic [AHBW/8-1:0]     HWSTRB;
   logic [AHBW-1:0]       HRDATAEXT;
   logic                  HREADYEXT;
   logic                  HRESPEXT;

   modport master (
      output HSELEXT, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA, HWSTRB,
      input  HRDATAEXT, HREADYEXT, HRESPEXT
   );

   modport slave (
      input  HSELEXT, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA, HWSTRB,
      output HRDATAEXT, HREADYEXT, HRESPEXT
   );
endinterface

// File: rtl/ahb_ext_ram_sub.sv
// AHB-Lite subordinate RAM with programmable wait states, byte-strobed
// writes and two-cycle ERROR responses for out-of-window or oversize accesses.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | no data phase in progress, ready/OKAY
// ST_WAIT | OKAY data phase stalled, counter runs down to 0
// ST_XFER | OKAY data phase completes this cycle (write commits on edge)
// ST_ERR1 | first ERROR cycle, ready low
// ST_ERR2 | second ERROR cycle, ready high, memory untouched
module ahb_ext_ram_sub #(
   parameter int          AHBW       = 64,
   parameter int          PA_BITS    = 56,
   parameter logic [63:0] BASE       = 64'h8000_0000,
   parameter int          DEPTH      = 1024,
   parameter int          WAITSTATES = 0
) (
   input  logic              clk,
   input  logic              reset,
   ahb_ext_ram_sub_if.slave  ahb
);

   localparam int          BYTES     = AHBW / 8;
   localparam int          LANE_W    = $clog2(BYTES);
   localparam int          IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [64:0] BASE_X    = {1'b0, BASE};
   localparam logic [64:0] LIMIT_X   = BASE_X + 65'(DEPTH) * 65'(BYTES);
   localparam logic [2:0]  WAIT_INIT = (WAITSTATES > 0) ? 3'(WAITSTATES - 1) : 3'd0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_XFER,
      ST_ERR1,
      ST_ERR2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [2:0]        cnt;
   logic [2:0]        cnt_nxt;
   logic [IDX_W-1:0]  idx_q;
   logic [IDX_W-1:0]  idx_nxt;
   logic              write_q;

   logic [AHBW-1:0]   mem [DEPTH];

   logic [64:0]       addr_x;
   logic [64:0]       offset;
   logic              in_range;
   logic              size_ok;
   logic              legal;
   logic              can_accept;
   logic              accept;
   logic              unused_bits;

   // Address decode is done at 65 bits so BASE + window size cannot wrap.
   assign addr_x     = 65'(ahb.HADDR);
   assign offset     = addr_x - BASE_X;
   assign in_range   = (addr_x >= BASE_X) && (addr_x < LIMIT_X);
   assign size_ok    = (ahb.HSIZE <= 3'(LANE_W));
   assign legal      = in_range && size_ok;
   assign idx_nxt    = offset[LANE_W +: IDX_W];

   assign can_accept = (state == ST_IDLE) || (state == ST_XFER) || (state == ST_ERR2);
   assign accept     = can_accept && ahb.HSELEXT && ahb.HREADY && ahb.HTRANS[1];

   assign unused_bits = ^{offset, ahb.HTRANS[0]};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= ST_IDLE;
         cnt     <= 3'd0;
         idx_q   <= '0;
         write_q <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (accept) begin
            idx_q   <= idx_nxt;
            write_q <= ahb.HWRITE;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         ST_IDLE, ST_XFER, ST_ERR2: begin
            state_nxt = ST_IDLE;
            if (accept) begin
               if (!legal) begin
                  state_nxt = ST_ERR1;
               end else if (WAITSTATES > 0) begin
                  state_nxt = ST_WAIT;
                  cnt_nxt   = WAIT_INIT;
               end else begin
                  state_nxt = ST_XFER;
               end
            end
         end
         ST_WAIT: begin
            if (cnt == 3'd0) begin
               state_nxt = ST_XFER;
            end else begin
               cnt_nxt = cnt - 3'd1;
            end
         end
         ST_ERR1: state_nxt = ST_ERR2;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      ahb.HREADYEXT = 1'b1;
      ahb.HRESPEXT  = 1'b0;
      ahb.HRDATAEXT = '0;
      case (state)
         ST_WAIT: ahb.HREADYEXT = 1'b0;
         ST_XFER: ahb.HRDATAEXT = mem[idx_q];
         ST_ERR1: begin
            ahb.HREADYEXT = 1'b0;
            ahb.HRESPEXT  = 1'b1;
         end
         ST_ERR2: ahb.HRESPEXT = 1'b1;
         default: ;
      endcase
   end

   // RAM array is deliberately not reset; reset forces ST_IDLE so a pending
   // write never reaches this block.
   always_ff @(posedge clk) begin
      if ((state == ST_XFER) && write_q) begin
         for (int i = 0; i < BYTES; i++) begin
            if (ahb.HWSTRB[i]) begin
               mem[idx_q][8*i +: 8] <= ahb.HWDATA[8*i +: 8];
            end
         end
      end
   end

endmodule
